cla_modadd_seq: RTL and testbench

Iterative modular adder/subtractor for the NTT/FFT butterfly datapath. It computes (a+b) mod q or (a−b) mod q on DATA_W-bit operands by reusing a single 4-bit carry-lookahead slice, one nibble per cycle, LSB first. Two passes are made: a raw add/sub, then a correction against q. The block trades latency for area in configurations where a full-width adder per butterfly is too costly.

---
 rtl/cla_modadd_seq_pkg.sv | 13 +
 rtl/cla_modadd_seq_cla4.sv | 27 ++
 rtl/cla_modadd_seq.sv | 140 ++++++++++++++
 tb/tb_cla_modadd_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_modadd_seq_pkg.sv
// rtl/cla_modadd_seq_pkg.sv - state encoding and width default for the serial modular adder
package cla_modadd_seq_pkg;

    localparam int DATA_W_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cla_modadd_seq_cla4.sv
// rtl/cla_modadd_seq_cla4.sv - 4-bit carry-lookahead slice with group generate/propagate
module cla_modadd_seq_cla4 (
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       g_out,
    output logic       p_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g     = a_in & b_in;
        p     = a_in ^ b_in;
        c[0]  = c_in;
        c[1]  = g[0] | (p[0] & c_in);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
        sum   = p ^ c;
        g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        p_out = &p;
    end

endmodule

// File: rtl/cla_modadd_seq.sv
// rtl/cla_modadd_seq.sv - nibble-serial (a+b) mod q / (a-b) mod q using one shared CLA4 slice
module cla_modadd_seq
    import cla_modadd_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              op_sub,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] q_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_out
);

    localparam int SLICES = DATA_W / 4;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SLICES - 1);

    state_t state, state_nxt;

    logic [DATA_W-1:0] a_r, b_r, q_r, s_r, t_r;
    logic              sub_r, c_r, c1_r, c2_r;
    logic [IDX_W-1:0]  k;
    logic [IDX_W+1:0]  sh;

    logic [3:0]        nib_a, nib_b, sum;
    logic              g_out, p_out, c_out;
    logic [DATA_W-1:0] nib_mask, nib_ins, res_sel;

    assign sh = {k, 2'b00};

    always_comb begin
        nib_a = 4'(a_r >> sh);
        nib_b = 4'(b_r >> sh);
        if (state == PASS2) begin
            // Add corrects by s - q (two's complement); sub corrects by s + q.
            nib_a = 4'(s_r >> sh);
            nib_b = sub_r ? 4'(q_r >> sh) : ~4'(q_r >> sh);
        end else if (sub_r) begin
            nib_b = ~4'(b_r >> sh);
        end
    end

    cla_modadd_seq_cla4 u_cla4 (
        .a_in  (nib_a),
        .b_in  (nib_b),
        .c_in  (c_r),
        .sum   (sum),
        .g_out (g_out),
        .p_out (p_out)
    );

    always_comb begin
        c_out    = g_out | (p_out & c_r);
        nib_mask = DATA_W'(4'hF) << sh;
        nib_ins  = DATA_W'(sum) << sh;
        // For sub, c1 set means a >= b so the raw difference is already reduced.
        res_sel  = sub_r ? (c1_r ? s_r : t_r) : ((c1_r | c2_r) ? t_r : s_r);
    end

    always_comb begin
        state_nxt   = state;
        start_ready = (state == IDLE);
        case (state)
            IDLE:    if (start_valid)           state_nxt = PASS1;
            PASS1:   if (k == LAST)             state_nxt = PASS2;
            PASS2:   if (k == LAST)             state_nxt = DONE;
            DONE:    if (res_valid && res_ready) state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            q_r       <= '0;
            s_r       <= '0;
            t_r       <= '0;
            sub_r     <= 1'b0;
            c_r       <= 1'b0;
            c1_r      <= 1'b0;
            c2_r      <= 1'b0;
            k         <= '0;
            res_valid <= 1'b0;
            res_out   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r   <= a_in;
                        b_r   <= b_in;
                        q_r   <= q_in;
                        sub_r <= op_sub;
                        c_r   <= op_sub;
                        k     <= '0;
                    end
                end
                PASS1: begin
                    s_r <= (s_r & ~nib_mask) | nib_ins;
                    c_r <= c_out;
                    if (k == LAST) begin
                        k    <= '0;
                        c1_r <= c_out;
                        c_r  <= ~sub_r;
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                PASS2: begin
                    t_r <= (t_r & ~nib_mask) | nib_ins;
                    c_r <= c_out;
                    if (k == LAST) begin
                        k    <= '0;
                        c2_r <= c_out;
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (!res_valid) begin
                        res_out   <= res_sel;
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_modadd_seq.sv
// tb/tb_cla_modadd_seq.sv - vector table, corner sequences and random regression for cla_modadd_seq
module tb_cla_modadd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sv16 = 1'b0, sr16, sub16 = 1'b0, rv16, rr16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0, q16 = 16'hFFF1, r16;

    logic        sv4 = 1'b0, sr4, sub4 = 1'b0, rv4, rr4 = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0, q4 = 4'hD, r4;

    cla_modadd_seq #(.DATA_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv16), .start_ready(sr16),
        .op_sub(sub16), .a_in(a16), .b_in(b16), .q_in(q16),
        .res_valid(rv16), .res_ready(rr16), .res_out(r16)
    );

    cla_modadd_seq #(.DATA_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
        .op_sub(sub4), .a_in(a4), .b_in(b4), .q_in(q4),
        .res_valid(rv4), .res_ready(rr4), .res_out(r4)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint model(input bit sub, input longint a, input longint b, input longint q);
        if (sub) return (a + q - b) % q;
        return (a + b) % q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run16(input bit sub, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, output logic [15:0] res, output int lat);
        int t0;
        int n;
        res = '0;
        lat = -1;
        n = 0;
        while (!sr16 && n < 50) begin tick(); n++; end
        sub16 = sub; a16 = a; b16 = b; q16 = q; sv16 = 1'b1;
        tick();
        sv16 = 1'b0;
        t0 = cyc;
        n = 0;
        while (!rv16 && n < 100) begin tick(); n++; end
        if (!rv16) begin
            chk("timeout16", 0, 1);
        end else begin
            res = r16;
            lat = cyc - t0;
            tick();
        end
    endtask

    task automatic run4(input bit sub, input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] res, output int lat);
        int t0;
        int n;
        res = '0;
        lat = -1;
        n = 0;
        while (!sr4 && n < 50) begin tick(); n++; end
        sub4 = sub; a4 = a; b4 = b; sv4 = 1'b1;
        tick();
        sv4 = 1'b0;
        t0 = cyc;
        n = 0;
        while (!rv4 && n < 50) begin tick(); n++; end
        if (!rv4) begin
            chk("timeout4", 0, 1);
        end else begin
            res = r4;
            lat = cyc - t0;
            tick();
        end
    endtask

    initial begin
        logic [15:0] res, q, a, b;
        logic [3:0]  res4;
        int          lat, t0, n, bad_rand, bad_lat, stale;
        bit          sub;

        tbl[0] = '{1'b0, 16'h0005, 16'h0007, 16'h000C};
        tbl[1] = '{1'b0, 16'hFFF0, 16'h0005, 16'h0004};
        tbl[2] = '{1'b0, 16'hFFF0, 16'hFFF0, 16'hFFEF};
        tbl[3] = '{1'b1, 16'h0003, 16'h0005, 16'hFFEF};
        tbl[4] = '{1'b1, 16'h0005, 16'h0003, 16'h0002};
        tbl[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000};

        #1;
        chk("reset_res_valid", rv16, 0);
        chk("reset_res_out", r16, 0);
        chk("reset_start_ready", sr16, 1);
        chk("reset_res_valid_w4", rv4, 0);
        chk("reset_start_ready_w4", sr4, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run16(tbl[i].sub, tbl[i].a, tbl[i].b, 16'hFFF1, res, lat);
            chk($sformatf("vec%0d_res", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 9);
        end

        // Backpressure: result held, new request ignored until the handshake.
        rr16 = 1'b0;
        sub16 = 1'b0; a16 = 16'h0001; b16 = 16'h0002; q16 = 16'hFFF1; sv16 = 1'b1;
        tick();
        sv16 = 1'b0;
        n = 0;
        while (!rv16 && n < 100) begin tick(); n++; end
        chk("bp_valid_seen", rv16, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a16 = 16'h0007; b16 = 16'h0007; sv16 = 1'b1;
            end
            tick();
            sv16 = 1'b0;
            chk($sformatf("bp_hold_res_%0d", i), r16, 16'h0003);
            chk($sformatf("bp_hold_valid_%0d", i), rv16, 1);
            chk($sformatf("bp_hold_ready_%0d", i), sr16, 0);
        end
        a16 = 16'h0004; b16 = 16'h0004; sv16 = 1'b1; rr16 = 1'b1;
        tick();
        chk("bp_release_valid", rv16, 0);
        chk("bp_release_ready", sr16, 1);
        tick();
        sv16 = 1'b0;
        t0 = cyc;
        chk("bp_next_accepted", sr16, 0);
        n = 0;
        while (!rv16 && n < 100) begin tick(); n++; end
        chk("bp_next_res", r16, 16'h0008);
        chk("bp_next_latency", cyc - t0, 9);
        tick();

        // Reset while PASS2 is in progress.
        sub16 = 1'b0; a16 = 16'h0100; b16 = 16'h0200; sv16 = 1'b1;
        tick();
        sv16 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", rv16, 0);
        chk("rst_mid_ready", sr16, 1);
        tick();
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rv16) stale++;
        end
        chk("rst_no_stale", stale, 0);
        run16(1'b0, 16'h0001, 16'h0001, 16'hFFF1, res, lat);
        chk("post_rst_res", res, 16'h0002);
        chk("post_rst_latency", lat, 9);

        // Random regression on the 16-bit build.
        bad_rand = 0;
        bad_lat = 0;
        for (int i = 0; i < 2000; i++) begin
            q = (i % 50 == 0) ? 16'd1 : 16'($urandom_range(65535, 1));
            a = 16'($urandom_range(int'(q) - 1, 0));
            b = 16'($urandom_range(int'(q) - 1, 0));
            sub = 1'($urandom_range(1, 0));
            run16(sub, a, b, q, res, lat);
            n_vec++;
            if (longint'(res) != model(sub, a, b, q) || lat != 9) begin
                n_bad++;
                if (bad_rand < 5)
                    $display("FAIL rand16 sub=%0d a=%0h b=%0h q=%0h: got %0h lat %0d expected %0h lat 9",
                             sub, a, b, q, res, lat, model(sub, a, b, q));
                bad_rand++;
            end
        end

        // Exhaustive in-range operands on the 4-bit build.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 13; x++) begin
                for (int y = 0; y < 13; y++) begin
                    run4(1'(s), 4'(x), 4'(y), res4, lat);
                    n_vec++;
                    if (longint'(res4) != model(1'(s), x, y, 13) || lat != 3) begin
                        n_bad++;
                        if (bad_lat < 5)
                            $display("FAIL w4 sub=%0d a=%0h b=%0h: got %0h lat %0d expected %0h lat 3",
                                     s, x, y, res4, lat, model(1'(s), x, y, 13));
                        bad_lat++;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
